// File: rtl/coproc_shift_pkg.sv
// Shared constants, FSM state type and merge-mask helper for the wide shift sequencer.
package coproc_shift_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } wshift_state_e;

  // Ones over the bits a rotated word keeps from its own source word.
  function automatic logic [WORD_W-1:0] merge_mask(input logic [4:0] b);
    return 32'hFFFFFFFF >> b;
  endfunction

endpackage

// File: rtl/coproc_wide_shift_ctrl_rshifter32.sv
// 32-bit right shifter / right rotator; purely combinational, shared word datapath.
module rshifter32
  import coproc_shift_pkg::*;
(
  input  logic [WORD_W-1:0] d,
  input  logic [4:0]        shift_amount,
  input  logic              rotate_en,
  output logic [WORD_W-1:0] q
);

  // A left shift by 32 (shift_amount == 0) yields zero, so rotate-by-0 is identity.
  assign q = (d >> shift_amount) |
             (rotate_en ? (d << (6'(WORD_W) - {1'b0, shift_amount})) : '0);

endmodule

// File: rtl/coproc_wide_shift_ctrl.sv
// Wide logical right shift / rotate sequencer, one source word per cycle through a shared rshifter32.
// Optional arithmetic (sign-fill) shift mode under COPROC_WIDE_SHIFT_ARITH_EN.
module coproc_wide_shift_ctrl
  import coproc_shift_pkg::*;
#(
  parameter  int WORDS   = 4,
  localparam int SHAMT_W = $clog2(WORDS * WORD_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WORDS*WORD_W-1:0] req_data,
  input  logic [SHAMT_W-1:0]      req_shamt,
  input  logic                    req_rotate,
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
  input  logic                    req_arith,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WORDS*WORD_W-1:0] resp_data,
  output logic                    busy
);

  localparam int IDX_W = SHAMT_W - 5;
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ROT  = ROT;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]              state_q, state_d;
  logic [WORDS*WORD_W-1:0] src_q, src_d;
  logic [SHAMT_W-1:0]      shamt_q, shamt_d;
  logic                    rotate_q, rotate_d;
  logic [CNT_W-1:0]        j_q, j_d;
  logic [WORD_W-1:0]       r_prev_q, r_prev_d;
  logic [WORDS*WORD_W-1:0] out_q, out_d;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
  logic                    arith_q, arith_d;
`endif

  logic [IDX_W-1:0]  k;
  logic [4:0]        b;
  logic [CNT_W-1:0]  s;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] fill_word;
  logic [WORD_W-1:0] src_word;
  logic [WORD_W-1:0] rot_word;
  logic [WORD_W-1:0] mask;

  assign k      = shamt_q[SHAMT_W-1:5];
  assign b      = shamt_q[4:0];
  assign s      = j_q + CNT_W'(k);
  assign wr_idx = IDX_W'(j_q - 1'b1);
  assign mask   = merge_mask(b);

`ifdef COPROC_WIDE_SHIFT_ARITH_EN
  assign fill_word = (arith_q && src_q[WORDS*WORD_W-1]) ? '1 : '0;
`else
  assign fill_word = '0;
`endif

  // s[IDX_W] set means the source index ran past the top word.
  assign src_word = (!rotate_q && s[IDX_W]) ? fill_word
                                            : src_q[s[IDX_W-1:0]*WORD_W +: WORD_W];

  rshifter32 u_rshifter32 (
    .d            (src_word),
    .shift_amount (b),
    .rotate_en    (1'b1),
    .q            (rot_word)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    shamt_d  = shamt_q;
    rotate_d = rotate_q;
    j_d      = j_q;
    r_prev_d = r_prev_q;
    out_d    = out_q;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
    arith_d  = arith_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          src_d    = req_data;
          shamt_d  = req_shamt;
          rotate_d = req_rotate;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
          arith_d  = req_arith && !req_rotate;
`endif
          j_d      = '0;
          state_d  = ST_ROT;
        end
      end
      ST_ROT: begin
        r_prev_d = rot_word;
        j_d      = j_q + 1'b1;
        // Low bits come from the previous rotated word, high bits wrap in from this one.
        if (j_q != '0) begin
          out_d[wr_idx*WORD_W +: WORD_W] = (r_prev_q & mask) | (rot_word & ~mask);
        end
        if (j_q == CNT_W'(WORDS)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      shamt_q  <= '0;
      rotate_q <= 1'b0;
      j_q      <= '0;
      r_prev_q <= '0;
      out_q    <= '0;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      shamt_q  <= shamt_d;
      rotate_q <= rotate_d;
      j_q      <= j_d;
      r_prev_q <= r_prev_d;
      out_q    <= out_d;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
      arith_q  <= arith_d;
`endif
    end
  end

  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_data  = out_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coproc_wide_shift_ctrl.sv
// Scoreboard bench for coproc_wide_shift_ctrl (WORDS=4) with directed hand-computed vectors.
module tb_coproc_wide_shift_ctrl;

  localparam int WORDS = 4;
  localparam int DW    = WORDS * 32;
  localparam int SW    = 7;

  localparam logic [DW-1:0] PAT = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic [SW-1:0] req_shamt = '0;
  logic          req_rotate = 1'b0;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
  logic          req_arith = 1'b0;
`endif
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  string         name_q[$];

  always #5 clk = ~clk;

  coproc_wide_shift_ctrl #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shamt  (req_shamt),
    .req_rotate (req_rotate),
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
    .req_arith  (req_arith),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got %h expected no response", resp_data);
      end else begin
        check(name_q.pop_front(), resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input string name, input logic [DW-1:0] d, input logic [SW-1:0] sh,
                      input logic rot, input logic ar, input bit push, input logic [DW-1:0] exp);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept: req_ready=0 after %0d cycles, expected 1", name, n);
      return;
    end
    req_valid  = 1'b1;
    req_data   = d;
    req_shamt  = sh;
    req_rotate = rot;
`ifdef COPROC_WIDE_SHIFT_ARITH_EN
    req_arith  = ar;
`else
    if (ar) $display("note: arith request issued without arithmetic build");
`endif
    if (push) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: pending=%0d busy=%0b, expected 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [DW-1:0] bp_exp;

    // Reset state
    #12;
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_resp_valid", DW'(resp_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_resp_data", resp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_req_ready", DW'(req_ready), DW'(1));
    @(posedge clk); #1;

    // Identity plus request-to-response latency
    send("identity", PAT, 7'd0, 1'b0, 1'b0, 1'b1, PAT);
    lat = 1;
    @(posedge clk); #1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", DW'(lat), DW'(5));
    wait_done("identity");

    send("logic_36", PAT, 7'd36, 1'b0, 1'b0, 1'b1, 128'h00000000_0AAAAAAA_ABBBBBBB_BCCCCCCC);
    send("rot_36", PAT, 7'd36, 1'b1, 1'b0, 1'b1, 128'hCDDDDDDD_DAAAAAAA_ABBBBBBB_BCCCCCCC);
    send("logic_4", PAT, 7'd4, 1'b0, 1'b0, 1'b1, 128'h0AAAAAAA_ABBBBBBB_BCCCCCCC_CDDDDDDD);
    send("logic_32", PAT, 7'd32, 1'b0, 1'b0, 1'b1, 128'h00000000_AAAAAAAA_BBBBBBBB_CCCCCCCC);
    send("rot_64", PAT, 7'd64, 1'b1, 1'b0, 1'b1, 128'hCCCCCCCC_DDDDDDDD_AAAAAAAA_BBBBBBBB);
    send("rot_0", PAT, 7'd0, 1'b1, 1'b0, 1'b1, PAT);
    send("rot_max", 128'h1, 7'd127, 1'b1, 1'b0, 1'b1, 128'h2);
    send("logic_max", 128'h80000000_00000000_00000000_00000000, 7'd127, 1'b0, 1'b0, 1'b1, 128'h1);
    send("logic_max_ones", {DW{1'b1}}, 7'd127, 1'b0, 1'b0, 1'b1, 128'h1);
    wait_done("directed");

    // Backpressure: result held, new request refused while DONE
    resp_ready = 1'b0;
    bp_exp = 128'hCDDDDDDD_DAAAAAAA_ABBBBBBB_BCCCCCCC;
    send("bp", PAT, 7'd36, 1'b1, 1'b0, 1'b1, bp_exp);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_data   = 128'h12345678;
    req_shamt  = 7'd8;
    req_rotate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_resp_valid", DW'(resp_valid), DW'(1));
      check("bp_resp_data", resp_data, bp_exp);
      check("bp_req_ready", DW'(req_ready), DW'(0));
      check("bp_busy", DW'(busy), DW'(1));
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    wait_done("bp");
    check("bp_ready_after", DW'(req_ready), DW'(1));

    // Reset during ROT step 2 discards the operation
    send("rst_op", PAT, 7'd36, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", DW'(resp_valid), DW'(0));
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_resp_data", resp_data, '0);
    check("midrst_req_ready", DW'(req_ready), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("after_rst", 128'hF0, 7'd4, 1'b0, 1'b0, 1'b1, 128'h0F);
    wait_done("after_rst");

`ifdef COPROC_WIDE_SHIFT_ARITH_EN
    send("arith_124", 128'h80000000_00000000_00000000_00000000, 7'd124, 1'b0, 1'b1, 1'b1,
         128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF8);
    send("arith_rot_override", 128'h80000000_00000000_00000000_00000000, 7'd124, 1'b1, 1'b1, 1'b1,
         128'h00000000_00000000_00000000_00000008);
    wait_done("arith");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
